clk_enable_scheduler: RTL
=========================

Name: clk_enable_scheduler

Overview:
- Sequences all subsystem clock enables derived from the 8.4MHz core clk.
- Holds the core idle until the PLL reports lock, then issues CPU/PPU/APU enables for the selected speed mode (normal or CGB double speed).
- Supports debug pause/single-step and the STOP-driven speed-switch stall.
- Owns the 16-bit DIV counter that feeds the timer block.

Parameters:
- SWITCH_STALL, 2048: clk cycles all enables are held low during a speed switch.
- STEP_CYCLES, 8: clk cycles enables run per single-step request (must be even, ≥2).
- LOCK_SYNC, 2: synchronizer depth for pll_locked.

Ports:
- clk  in  1  core clock, 8.388608MHz
- reset_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- pause_req  in  1  level; 1 = hold core
- step_req  in  1  one-clk pulse; advance STEP_CYCLES while paused
- speed_switch_req  in  1  one-clk pulse from CPU STOP with KEY1 armed
- div_clear  in  1  one-clk pulse; CPU write to DIV
- cpu_en  out  1  CPU clock enable
- ppu_en  out  1  PPU clock enable, always 4.19MHz rate
- apu_en  out  1  APU clock enable, always 4.19MHz rate
- div  out  16  free-running divider; timer taps bits
- double_speed  out  1  current speed mode
- state  out  3  FSM state encoding, for debug

Behaviour:
- Reset (async, reset_n=0): state=WAIT_LOCK, cpu_en=ppu_en=apu_en=0, div=0, double_speed=0, phase=0, counters=0.
- lock_s is pll_locked after a LOCK_SYNC-flop synchronizer; its reset value is 0.
- States: WAIT_LOCK=0, RUN=1, PAUSED=2, STEP=3, SWITCH=4.
- WAIT_LOCK:
  - All enables are 0.
  - When lock_s=1: go to PAUSED if pause_req, else RUN. phase=0.
- phase toggles every clk in RUN and STEP. It holds in the other states.
- Enables are registered outputs and valid in RUN/STEP only:
  - ppu_en = apu_en = (phase==1).
  - cpu_en = (phase==1) when double_speed=0; cpu_en = 1 every clk when double_speed=1.
  - First enable occurs on the 2nd clk after entering RUN.
- div increments by 1 (wraps 0xFFFF→0x0000) on each clk where cpu_en=1. div_clear sets div=0 on the next clk and has priority over increment. div holds in non-run states.
- RUN:
  - pause_req=1 → PAUSED.
  - speed_switch_req=1 → SWITCH: stall counter=0, div=0.
- PAUSED:
  - Enables are 0.
  - pause_req=0 → RUN with phase preserved.
  - step_req=1 → STEP: step counter=0.
- STEP:
  - Runs exactly STEP_CYCLES clks with RUN enable rules.
  - Then returns to PAUSED, or to RUN if pause_req has dropped.
  - step_req during STEP is ignored.
- SWITCH:
  - Enables are 0. Counts SWITCH_STALL clks.
  - On the final count: double_speed toggles, phase=0, go to RUN.
  - pause_req is ignored until the switch completes.
- Priority when events coincide: lock loss > pause_req > speed_switch_req > step_req.
- Lock loss (lock_s=0) in any state:
  - Next clk: state=WAIT_LOCK, enables=0.
  - An in-progress SWITCH is abandoned; double_speed is unchanged and div is kept.
- speed_switch_req outside RUN is ignored.
- Mid-operation reset returns everything to reset values immediately, including in SWITCH and STEP.

Optional Feature:
- Macro: CLK_SCHED_SINGLE_STEP_EN.
- Defined: STEP state and step counter exist, and step_req behaves as above.
- Undefined: STEP state is not present and step_req is ignored. PAUSED exits only via pause_req=0 or lock loss. State encoding 3 is unused.

Test Plan:
- Release reset with pll_locked=0 for 100 clks, then 1, pause_req=0 → enables stay 0 until 2 clks after sync; then state=RUN, ppu_en alternating 0/1, cpu_en==ppu_en, div increments every 2 clks (div=50 after 100 clks in RUN).
- RUN, pulse speed_switch_req → div=0, all enables 0 for exactly 2048 clks; then double_speed=1, cpu_en=1 every clk, ppu_en every 2nd clk, div increments every clk.
- Assert pause_req in RUN at div=0x0010, hold 40 clks, pulse step_req → enables 0 while paused; exactly 8 clks of enables in STEP (4 cpu_en pulses, normal speed); div=0x0014; state back to PAUSED.
- Force div to 0xFFFF in RUN with one more cpu_en pulse → div=0x0000. Pulse div_clear on the same clk as cpu_en → div=0.
- Drop pll_locked mid-SWITCH at stall count 1000 → WAIT_LOCK after sync; double_speed unchanged. Relock → RUN at the original speed.
- Assert reset_n=0 during STEP → outputs go to reset values asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/clk_enable_scheduler.sv
// clk_enable_scheduler
// Sequences CPU/PPU/APU clock enables from the 8.4MHz core clock: holds the
// core idle until PLL lock, handles debug pause, the STOP speed-switch stall
// and owns the 16-bit DIV counter.
// Optional feature macro: CLK_SCHED_SINGLE_STEP_EN (adds the STEP state and
// single-step handling; without it step_req is ignored and encoding 3 unused).
// Enable timing: an enable is high during a clk cycle when the state in that
// cycle is RUN/STEP and the phase of that cycle qualifies. Outputs are
// registered copies computed from the next-state values.

module clk_enable_scheduler #(
  parameter int SWITCH_STALL = 2048,
  parameter int STEP_CYCLES  = 8,
  parameter int LOCK_SYNC    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        pause_req,
  input  logic        step_req,
  input  logic        speed_switch_req,
  input  logic        div_clear,
  output logic        cpu_en,
  output logic        ppu_en,
  output logic        apu_en,
  output logic [15:0] div,
  output logic        double_speed,
  output logic [2:0]  state
);

  localparam int STALL_W = (SWITCH_STALL > 1) ? $clog2(SWITCH_STALL) : 1;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_RUN       = 3'd1,
    ST_PAUSED    = 3'd2,
`ifdef CLK_SCHED_SINGLE_STEP_EN
    ST_STEP      = 3'd3,
`endif
    ST_SWITCH    = 3'd4
  } state_t;

  // True for states in which the enables are generated and phase advances.
  function automatic logic is_active(input state_t s);
    logic act;
    case (s)
      ST_RUN:  act = 1'b1;
`ifdef CLK_SCHED_SINGLE_STEP_EN
      ST_STEP: act = 1'b1;
`endif
      default: act = 1'b0;
    endcase
    return act;
  endfunction

  logic [LOCK_SYNC-1:0] lock_sync_r;
  logic                 lock_s;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 phase_r;
  logic                 phase_nxt_s;
  logic                 double_speed_r;
  logic                 double_speed_nxt_s;
  logic [STALL_W-1:0]   stall_cnt_r;
  logic [STALL_W-1:0]   stall_cnt_nxt_s;
  logic                 switch_clr_s;

  logic                 active_nxt_s;
  logic                 cpu_en_nxt_s;
  logic                 ppu_en_nxt_s;
  logic                 cpu_en_r;
  logic                 ppu_en_r;
  logic                 apu_en_r;
  logic [15:0]          div_r;

`ifdef CLK_SCHED_SINGLE_STEP_EN
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  logic [STEP_W-1:0]    step_cnt_r;
  logic [STEP_W-1:0]    step_cnt_nxt_s;
`else
  logic                 unused_step_s;
  assign unused_step_s = step_req;
`endif

  assign lock_s = lock_sync_r[LOCK_SYNC-1];

  // Synchronize the asynchronous PLL lock into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_r <= '0;
    end else begin
      lock_sync_r <= (lock_sync_r << 1) | LOCK_SYNC'(pll_locked);
    end
  end

  // Next-state, phase, speed mode and counter decisions; lock loss wins.
  always_comb begin
    state_nxt_s        = state_r;
    phase_nxt_s        = phase_r;
    double_speed_nxt_s = double_speed_r;
    stall_cnt_nxt_s    = stall_cnt_r;
    switch_clr_s       = 1'b0;
`ifdef CLK_SCHED_SINGLE_STEP_EN
    step_cnt_nxt_s     = step_cnt_r;
`endif
    if (!lock_s) begin
      state_nxt_s = ST_WAIT_LOCK;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          phase_nxt_s = 1'b0;
          if (pause_req) begin
            state_nxt_s = ST_PAUSED;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_RUN: begin
          phase_nxt_s = ~phase_r;
          if (pause_req) begin
            state_nxt_s = ST_PAUSED;
          end else if (speed_switch_req) begin
            state_nxt_s     = ST_SWITCH;
            stall_cnt_nxt_s = '0;
            switch_clr_s    = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (!pause_req) begin
            state_nxt_s = ST_RUN;
          end
`ifdef CLK_SCHED_SINGLE_STEP_EN
          else if (step_req) begin
            state_nxt_s    = ST_STEP;
            step_cnt_nxt_s = '0;
          end
`endif
          else begin
            state_nxt_s = ST_PAUSED;
          end
        end
`ifdef CLK_SCHED_SINGLE_STEP_EN
        ST_STEP: begin
          phase_nxt_s = ~phase_r;
          if (step_cnt_r == STEP_W'(STEP_CYCLES - 1)) begin
            step_cnt_nxt_s = '0;
            if (pause_req) begin
              state_nxt_s = ST_PAUSED;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            step_cnt_nxt_s = step_cnt_r + STEP_W'(1);
          end
        end
`endif
        ST_SWITCH: begin
          if (stall_cnt_r == STALL_W'(SWITCH_STALL - 1)) begin
            double_speed_nxt_s = ~double_speed_r;
            phase_nxt_s        = 1'b0;
            stall_cnt_nxt_s    = '0;
            state_nxt_s        = ST_RUN;
          end else begin
            stall_cnt_nxt_s = stall_cnt_r + STALL_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  // Enable values for the upcoming cycle, derived from next state and phase.
  always_comb begin
    active_nxt_s = is_active(state_nxt_s);
    ppu_en_nxt_s = active_nxt_s & phase_nxt_s;
    if (double_speed_nxt_s) begin
      cpu_en_nxt_s = active_nxt_s;
    end else begin
      cpu_en_nxt_s = active_nxt_s & phase_nxt_s;
    end
  end

  // FSM state, phase, speed mode and stall/step counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_WAIT_LOCK;
      phase_r        <= 1'b0;
      double_speed_r <= 1'b0;
      stall_cnt_r    <= '0;
`ifdef CLK_SCHED_SINGLE_STEP_EN
      step_cnt_r     <= '0;
`endif
    end else begin
      state_r        <= state_nxt_s;
      phase_r        <= phase_nxt_s;
      double_speed_r <= double_speed_nxt_s;
      stall_cnt_r    <= stall_cnt_nxt_s;
`ifdef CLK_SCHED_SINGLE_STEP_EN
      step_cnt_r     <= step_cnt_nxt_s;
`endif
    end
  end

  // Registered clock-enable outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_en_r <= 1'b0;
      ppu_en_r <= 1'b0;
      apu_en_r <= 1'b0;
    end else begin
      cpu_en_r <= cpu_en_nxt_s;
      ppu_en_r <= ppu_en_nxt_s;
      apu_en_r <= ppu_en_nxt_s;
    end
  end

  // DIV counter: clears (CPU write or speed switch) beat CPU-rate increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= 16'h0000;
    end else if (div_clear || switch_clr_s) begin
      div_r <= 16'h0000;
    end else if (cpu_en_r) begin
      div_r <= div_r + 16'h0001;
    end else begin
      div_r <= div_r;
    end
  end

  assign cpu_en       = cpu_en_r;
  assign ppu_en       = ppu_en_r;
  assign apu_en       = apu_en_r;
  assign div          = div_r;
  assign double_speed = double_speed_r;
  assign state        = state_r;

endmodule
